// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MC_CONTROL_ADDI_EN to add addi (opcode 0x08) support; otherwise 0x08 traps.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtExec,
    StRtWb,
    StBranch,
    StJump,
    StTrap
`ifdef MC_CONTROL_ADDI_EN
    ,
    StAddiEx,
    StAddiWb
`endif
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [5:0] OpAddi  = 6'h08;
`endif

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluAnd = 2'b01;
  localparam logic [1:0] AluOr  = 2'b10;
  localparam logic [1:0] AluSub = 2'b11;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = AluAdd;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:    state_d = StRtExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef MC_CONTROL_ADDI_EN
          OpAddi:     state_d = StAddiEx;
`endif
          default:    state_d = StTrap;
        endcase
      end
      StRtExec: begin
        alu_src_a = 1'b1;
        state_d   = StRtWb;
        case (funct)
          6'h20:   alu_op = AluAdd;
          6'h24:   alu_op = AluAnd;
          6'h25:   alu_op = AluOr;
          6'h22:   alu_op = AluSub;
          default: state_d = StTrap;
        endcase
      end
      StRtWb: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = AluSub;
        pc_src     = 2'b01;
        pc_we      = zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`ifdef MC_CONTROL_ADDI_EN
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`endif
      StTrap: begin
        // Absorbing; sticky because only reset leaves this state.
        illegal = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule
